riscv_dual_issue_ctrl: RTL and testbench
========================================

Name: riscv_dual_issue_ctrl

Overview:
- In-order dual-issue steering controller for the 2-wide IO2I RISC-V core. Sits between decode and the X0 stage.
- Buffers one decoded instruction pair and issues up to two instructions per cycle.
- Pipe A executes ALU, MEM and MULDIV instructions; pipe B executes ALU only.
- Uses the scoreboard's per-register source-ready vector, ROB free-slot count and the iterative muldiv unit's occupancy to decide issue. Drives the scoreboard's A_issued/B_issued strobes.

Parameters:
- MULDIV_BUSY, 4, cycles after a MULDIV issue during which no other MULDIV may issue (muldiv unit is not pipelined).
- PAY_W, 32, width of the opaque instruction payload passed through to the execute pipes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_val  in  1  decode presents a pair
- in_rdy  out  1  controller accepts the pair this cycle
- in_ir0_info  in  20  older instruction, packed as {type[1:0], rd_en, rd[4:0], rs1_en, rs1[4:0], rs0_en, rs0[4:0]}; type: 00 ALU, 01 MEM, 10 MULDIV
- in_ir0_val  in  1  older slot holds a valid instruction
- in_ir0_pay  in  PAY_W  older instruction payload
- in_ir1_info  in  20  younger instruction, same packing
- in_ir1_val  in  1  younger slot holds a valid instruction
- in_ir1_pay  in  PAY_W  younger instruction payload
- src_ready  in  32  per-register operand-ready vector from the scoreboard
- rob_free  in  2  free ROB entries, saturating: 0, 1, 2 (3 is treated as 2)
- stall_X0hl  in  1  X0 stalled
- flush  in  1  squash buffered instructions (branch mispredict)
- A_issued  out  1  pipe A issues this cycle
- A_info  out  20  info of the instruction issued to A
- A_pay  out  PAY_W  payload issued to A
- B_issued  out  1  pipe B issues this cycle
- B_info  out  20  info of the instruction issued to B
- B_pay  out  PAY_W  payload issued to B
- muldiv_busy  out  1  muldiv occupancy counter is nonzero

Behaviour:
- Storage: two entries, E0 (older) and E1 (younger), each holding {val, info, pay}.
- States:
  - EMPTY: no valid entry.
  - PAIR: E0 and E1 both valid.
  - SINGLE: only E0 valid.
- Instruction ready (rdy(e)): e.val, AND (!rs0_en OR src_ready[rs0]), AND (!rs1_en OR src_ready[rs1]).
- MULDIV instructions also require muldiv counter == 0.
- go = !stall_X0hl && !flush. All issue is gated by go.
- Issue of E0 (i0): go && rdy(E0) && rob_free >= 1. E0 always issues to pipe A.
- Issue of E1 (i1): requires all of:
  - i0 (strict in-order issue)
  - E1.type == ALU
  - rob_free == 2
  - rdy(E1)
  - E1 does not read E0.rd when E0.rd_en, on either rs0 or rs1 (no intra-pair bypass)
- When i1 is true, E1 goes to pipe B.
- If E0 is ALU and E1 is not ALU, only E0 issues this cycle. E1 then becomes E0 next cycle and issues to pipe A.
- A_issued = i0; B_issued = i1. A_info/A_pay and B_info/B_pay are combinational from the entries and are don't-care when not issued.
- in_rdy = (state == EMPTY) || (go && i0 && (state == SINGLE || i1)). The controller refills in the same cycle the buffer drains.
- An accepted pair with in_ir0_val = 0 and in_ir1_val = 1 is loaded compacted into E0, giving SINGLE. A pair with both valid bits clear is ignored.
- Transitions:
  - PAIR with i0 and !i1 -> SINGLE (E1 shifts to E0).
  - PAIR with i0 and i1, or SINGLE with i0 -> EMPTY, or straight to a new PAIR/SINGLE if a pair is accepted that cycle.
  - Otherwise the state holds.
- Muldiv counter (3 bits):
  - Loads MULDIV_BUSY - 1 in the cycle a MULDIV issues on A.
  - Otherwise decrements toward 0, saturating at 0.
  - Not cleared by flush, because the unit stays occupied.
  - muldiv_busy = (counter != 0).
- flush: invalidates E0 and E1 (next state EMPTY), forces A_issued = B_issued = 0 and in_rdy = 0 that cycle. flush has priority over in_val.
- reset:
  - State EMPTY, counter 0.
  - A_issued = 0, B_issued = 0, muldiv_busy = 0 after the first reset edge; in_rdy = 1 once reset deasserts.
  - Reset mid-operation discards buffered instructions without issuing them.
- stall_X0hl: no issue; entries and state hold; the counter still decrements.

Test Plan:
- Two independent ALU instructions (E0 rd=x3, E1 rd=x4), rob_free=2, all sources ready -> A_issued=B_issued=1 in the same cycle; in_rdy=1; state EMPTY or refilled.
- ALU pair where E1 rs0=x3 and E0 rd=x3 -> cycle 1: A_issued only; cycle 2: E1 issues on A; in_rdy=0 in cycle 1 and 1 in cycle 2.
- MULDIV followed by MULDIV, MULDIV_BUSY=4 -> the first issues at cycle t; the second issues on A at t+4, not earlier; muldiv_busy is high for t+1..t+3.
- E0 with src_ready[rs0]=0 for 3 cycles while E1 is ready -> no issue for 3 cycles (E1 never bypasses E0); then both issue.
- rob_free=1 with a ready ALU pair -> only A issues; the next cycle, with rob_free=2, E1 issues on A.
- PAIR buffered with flush=1 and in_val=1 in the same cycle -> no issue and no accept; next cycle state EMPTY and in_rdy=1. Repeat with reset instead of flush -> same result, and the counter is cleared.

Source files
------------

// File: rtl/riscv_dual_issue_ctrl_if.sv
// Decode-to-X0 issue bus of the dual-issue steering controller.
// The master side is decode plus the scoreboard/ROB status; the slave side is the controller.
interface riscv_dual_issue_ctrl_if #(
  parameter int PAY_W = 32
);
  logic             in_val;
  logic             in_rdy;
  logic [19:0]      in_ir0_info;
  logic             in_ir0_val;
  logic [PAY_W-1:0] in_ir0_pay;
  logic [19:0]      in_ir1_info;
  logic             in_ir1_val;
  logic [PAY_W-1:0] in_ir1_pay;
  logic [31:0]      src_ready;
  logic [1:0]       rob_free;
  logic             stall_X0hl;
  logic             flush;
  logic             A_issued;
  logic [19:0]      A_info;
  logic [PAY_W-1:0] A_pay;
  logic             B_issued;
  logic [19:0]      B_info;
  logic [PAY_W-1:0] B_pay;
  logic             muldiv_busy;

  modport master (
    output in_val, in_ir0_info, in_ir0_val, in_ir0_pay,
           in_ir1_info, in_ir1_val, in_ir1_pay,
           src_ready, rob_free, stall_X0hl, flush,
    input  in_rdy, A_issued, A_info, A_pay, B_issued, B_info, B_pay, muldiv_busy
  );

  modport slave (
    input  in_val, in_ir0_info, in_ir0_val, in_ir0_pay,
           in_ir1_info, in_ir1_val, in_ir1_pay,
           src_ready, rob_free, stall_X0hl, flush,
    output in_rdy, A_issued, A_info, A_pay, B_issued, B_info, B_pay, muldiv_busy
  );
endinterface

// File: rtl/riscv_dual_issue_ctrl.sv
// In-order dual-issue steering: buffers one decoded pair, issues E0 to pipe A
// and, when independent and ALU, E1 to pipe B in the same cycle.
module riscv_dual_issue_ctrl #(
  parameter int MULDIV_BUSY = 4,
  parameter int PAY_W       = 32
) (
  input logic clk,
  input logic reset,
  riscv_dual_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SINGLE = 2'd1,
    PAIR   = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_ALU    = 2'b00;
  localparam logic [1:0] TYPE_MULDIV = 2'b10;
  localparam logic [2:0] MD_LOAD     = 3'(MULDIV_BUSY - 1);

  state_t           state, state_n;
  logic [19:0]      e0_info, e0_info_n, e1_info, e1_info_n;
  logic [PAY_W-1:0] e0_pay, e0_pay_n, e1_pay, e1_pay_n;
  logic [2:0]       md_cnt;

  logic go, e0_val, e1_val, e0_md, dep, i0, i1, in_rdy, accept;

  function automatic logic srcs_ok(input logic [19:0] info, input logic [31:0] ready);
    return (!info[5] || ready[info[4:0]]) && (!info[11] || ready[info[10:6]]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      md_cnt <= 3'd0;
    end else begin
      state <= state_n;
      if (i0 && e0_md)
        md_cnt <= MD_LOAD;
      else if (md_cnt != 3'd0)
        md_cnt <= md_cnt - 3'd1;
    end
    e0_info <= e0_info_n;
    e0_pay  <= e0_pay_n;
    e1_info <= e1_info_n;
    e1_pay  <= e1_pay_n;
  end

  // Entry valid bits follow directly from the occupancy state.
  always_comb begin
    e0_val = (state != EMPTY);
    e1_val = (state == PAIR);
    go     = !bus.stall_X0hl && !bus.flush && !reset;
    e0_md  = (e0_info[19:18] == TYPE_MULDIV);
    dep    = e0_info[17] &&
             ((e1_info[5]  && (e1_info[4:0]  == e0_info[16:12])) ||
              (e1_info[11] && (e1_info[10:6] == e0_info[16:12])));
    i0     = go && e0_val && srcs_ok(e0_info, bus.src_ready) &&
             (!e0_md || (md_cnt == 3'd0)) && (bus.rob_free != 2'd0);
    i1     = i0 && e1_val && (e1_info[19:18] == TYPE_ALU) && bus.rob_free[1] &&
             srcs_ok(e1_info, bus.src_ready) && !dep;
    in_rdy = !bus.flush && !reset &&
             ((state == EMPTY) || (i0 && ((state == SINGLE) || i1)));
    accept = bus.in_val && in_rdy;
  end

  // Next occupancy: flush wins, then a refill, then draining of issued entries.
  always_comb begin
    state_n   = state;
    e0_info_n = e0_info;
    e0_pay_n  = e0_pay;
    e1_info_n = e1_info;
    e1_pay_n  = e1_pay;
    if (bus.flush) begin
      state_n = EMPTY;
    end else if (accept) begin
      if (bus.in_ir0_val) begin
        e0_info_n = bus.in_ir0_info;
        e0_pay_n  = bus.in_ir0_pay;
        if (bus.in_ir1_val) begin
          e1_info_n = bus.in_ir1_info;
          e1_pay_n  = bus.in_ir1_pay;
          state_n   = PAIR;
        end else begin
          state_n = SINGLE;
        end
      end else if (bus.in_ir1_val) begin
        e0_info_n = bus.in_ir1_info;
        e0_pay_n  = bus.in_ir1_pay;
        state_n   = SINGLE;
      end else begin
        state_n = EMPTY;
      end
    end else if (i0) begin
      if ((state == PAIR) && !i1) begin
        e0_info_n = e1_info;
        e0_pay_n  = e1_pay;
        state_n   = SINGLE;
      end else begin
        state_n = EMPTY;
      end
    end
  end

  always_comb begin
    bus.in_rdy      = in_rdy;
    bus.A_issued    = i0;
    bus.A_info      = e0_info;
    bus.A_pay       = e0_pay;
    bus.B_issued    = i1;
    bus.B_info      = e1_info;
    bus.B_pay       = e1_pay;
    bus.muldiv_busy = (md_cnt != 3'd0);
  end

endmodule

// File: tb/tb_riscv_dual_issue_ctrl.sv
// Bench for riscv_dual_issue_ctrl: directed scenarios then random traffic,
// all checked against a queue-based model of the issue rules.
module tb_riscv_dual_issue_ctrl;

  localparam int MULDIV_BUSY = 4;
  localparam int PAY_W       = 32;

  typedef struct {
    logic [19:0]      info;
    logic [PAY_W-1:0] pay;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_md = -1000;
  ent_t q[$];

  riscv_dual_issue_ctrl_if #(.PAY_W(PAY_W)) bus ();

  riscv_dual_issue_ctrl #(.MULDIV_BUSY(MULDIV_BUSY), .PAY_W(PAY_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [1:0] t, input logic rd_en, input int rd,
                                     input logic rs1_en, input int rs1,
                                     input logic rs0_en, input int rs0);
    return {t, rd_en, 5'(rd), rs1_en, 5'(rs1), rs0_en, 5'(rs0)};
  endfunction

  function automatic bit operands_ready(input logic [19:0] info, input logic [31:0] r);
    bit ok = 1'b1;
    if (info[5] && !r[info[4:0]]) ok = 1'b0;
    if (info[11] && !r[info[10:6]]) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit reads_reg(input logic [19:0] info, input logic [4:0] r);
    return (info[5] && info[4:0] == r) || (info[11] && info[10:6] == r);
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic val,
                                input logic [19:0] info0, input logic v0,
                                input logic [19:0] info1, input logic v1,
                                input logic [31:0] ready, input logic [1:0] rob,
                                input logic stall, input logic fl);
    reset           = rst;
    bus.in_val      = val;
    bus.in_ir0_info = info0;
    bus.in_ir0_val  = v0;
    bus.in_ir0_pay  = $urandom;
    bus.in_ir1_info = info1;
    bus.in_ir1_val  = v1;
    bus.in_ir1_pay  = $urandom;
    bus.src_ready   = ready;
    bus.rob_free    = rob;
    bus.stall_X0hl  = stall;
    bus.flush       = fl;
  endtask

  // Evaluates the issue rules on the model buffer, compares, then advances one clock.
  task automatic check_output();
    int  n = q.size();
    int  since = cyc - last_md;
    int  rob_eff;
    bit  go, ok0, i0, i1, rdy, busy;
    #1;
    rob_eff = (bus.rob_free == 2'd3) ? 2 : int'(bus.rob_free);
    go   = !bus.stall_X0hl && !bus.flush && !reset;
    ok0  = (n >= 1) && operands_ready(q[0].info, bus.src_ready) &&
           (q[0].info[19:18] != 2'b10 || since >= MULDIV_BUSY);
    i0   = go && ok0 && rob_eff >= 1;
    i1   = i0 && n == 2 && q[1].info[19:18] == 2'b00 && rob_eff == 2 &&
           operands_ready(q[1].info, bus.src_ready) &&
           !(q[0].info[17] && reads_reg(q[1].info, q[0].info[16:12]));
    rdy  = !bus.flush && !reset && (n == 0 || (i0 && (n == 1 || i1)));
    busy = since >= 1 && since <= MULDIV_BUSY - 1;

    cmp("A_issued", 64'(bus.A_issued), 64'(i0));
    cmp("B_issued", 64'(bus.B_issued), 64'(i1));
    cmp("in_rdy", 64'(bus.in_rdy), 64'(rdy));
    cmp("muldiv_busy", 64'(bus.muldiv_busy), 64'(busy));
    if (i0) begin
      cmp("A_info", 64'(bus.A_info), 64'(q[0].info));
      cmp("A_pay", 64'(bus.A_pay), 64'(q[0].pay));
    end
    if (i1) begin
      cmp("B_info", 64'(bus.B_info), 64'(q[1].info));
      cmp("B_pay", 64'(bus.B_pay), 64'(q[1].pay));
    end

    if (i0 && q[0].info[19:18] == 2'b10) last_md = cyc;
    if (i1) void'(q.pop_front());
    if (i0) void'(q.pop_front());
    if (bus.flush) q.delete();
    if (bus.in_val && rdy) begin
      if (bus.in_ir0_val) q.push_back('{info: bus.in_ir0_info, pay: bus.in_ir0_pay});
      if (bus.in_ir1_val) q.push_back('{info: bus.in_ir1_info, pay: bus.in_ir1_pay});
    end
    if (reset) begin
      q.delete();
      last_md = -1000;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  initial begin
    logic [19:0] alu3, alu4, dep3, md5, md6, z;
    logic [19:0] r0, r1;
    logic [31:0] rdyv;
    z    = 20'd0;
    alu3 = mk(2'b00, 1, 3, 1, 1, 1, 2);
    alu4 = mk(2'b00, 1, 4, 1, 5, 1, 6);
    dep3 = mk(2'b00, 1, 7, 0, 0, 1, 3);
    md5  = mk(2'b10, 1, 5, 1, 1, 1, 2);
    md6  = mk(2'b10, 1, 6, 1, 8, 0, 0);

    apply_stimulus(1, 0, z, 0, z, 0, ALL, 2, 0, 0);
    @(posedge clk);
    #1;
    check_output();
    check_output();
    $display("[TB] reset released");

    // independent ALU pair issues together
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 0, 0); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    // intra-pair dependency splits the pair
    apply_stimulus(0, 1, alu3, 1, dep3, 1, ALL, 2, 0, 0); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    check_output();
    // back-to-back MULDIV spaced by the busy window
    apply_stimulus(0, 1, md5, 1, md6, 1, ALL, 2, 0, 0);   check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);
    for (int k = 0; k < 6; k++) check_output();
    // older instruction waits on an operand; younger never bypasses
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 0, 0); check_output();
    rdyv = ALL;
    rdyv[2] = 1'b0;
    apply_stimulus(0, 0, z, 0, z, 0, rdyv, 2, 0, 0);
    for (int k = 0; k < 3; k++) check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    // single ROB slot lets only pipe A go
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 0, 0); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 1, 0, 0);       check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    // compacted load of a lone younger slot
    apply_stimulus(0, 1, alu3, 0, alu4, 1, ALL, 2, 1, 0); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    // flush against a buffered pair and a simultaneous offer
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 0, 0); check_output();
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 0, 1); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    // reset against a buffered pair while muldiv is busy
    apply_stimulus(0, 1, md5, 1, alu4, 1, ALL, 2, 0, 0);  check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 1, 0);       check_output();
    apply_stimulus(0, 1, alu3, 1, alu4, 1, ALL, 2, 1, 0); check_output();
    apply_stimulus(1, 1, alu3, 1, alu4, 1, ALL, 2, 0, 0); check_output();
    apply_stimulus(0, 0, z, 0, z, 0, ALL, 2, 0, 0);       check_output();
    $display("[TB] directed steps done, starting random traffic");

    for (int k = 0; k < 600; k++) begin
      r0 = mk(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 7),
              1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7));
      r1 = mk(2'($urandom_range(0, 2)), 1'($urandom), $urandom_range(0, 7),
              1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7));
      apply_stimulus($urandom_range(0, 99) == 0, 1'($urandom),
                     r0, $urandom_range(0, 3) != 0, r1, $urandom_range(0, 3) != 0,
                     $urandom | $urandom, 2'($urandom), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 19) == 0);
      check_output();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
